// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the button conditioner.
// Holds the per-channel debounce state encoding and the counter-width helper.
package button_conditioner_pkg;

  // Debounce FSM states: two stable levels, each with a confirmation wait.
  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  // Counter width able to hold every value 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioner channel: STAGES-deep synchroniser followed by a debounce
// FSM with a confirmation counter. Produces a registered clean level plus
// one-cycle rise and fall pulses.
// Optional feature: define BUTTON_CONDITIONER_TOGGLE_EN to add a toggle bit
// that flips together with every rise pulse.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
`ifdef BUTTON_CONDITIONER_TOGGLE_EN
  output logic toggle,
`endif
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  // Last count value in a WAIT state; reaching it with a stable input
  // confirms the new level on the following edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [STAGES-1:0] sync_ff;
  logic              sync;
  state_t            state;
  logic [CNT_W-1:0]  count;

  // Synchroniser: raw enters stage 0, the last stage is the usable input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], raw};
    end
  end

  assign sync = sync_ff[STAGES-1];

  // Debounce FSM: level and pulses are registered and change on the same
  // edge as the state entering S_HIGH or S_LOW.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_LOW;
      count  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
`ifdef BUTTON_CONDITIONER_TOGGLE_EN
      toggle <= 1'b0;
`endif
    end else begin
      // Pulses are single-cycle unless a transition re-asserts them below.
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        S_LOW: begin
          if (sync) begin
            state <= S_WAIT_HIGH;
            count <= '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!sync) begin
            // Input fell back before confirmation: treat it as a bounce.
            state <= S_LOW;
            count <= '0;
          end else if (count == CNT_LAST) begin
            state <= S_HIGH;
            level <= 1'b1;
            rise  <= 1'b1;
`ifdef BUTTON_CONDITIONER_TOGGLE_EN
            toggle <= ~toggle;
`endif
          end else begin
            count <= count + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!sync) begin
            state <= S_WAIT_LOW;
            count <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (sync) begin
            // Input returned high before confirmation: treat it as a bounce.
            state <= S_HIGH;
            count <= '0;
          end else if (count == CNT_LAST) begin
            state <= S_LOW;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            count <= count + CNT_ONE;
          end
        end
        default: begin
          state <= S_LOW;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel input conditioner for joystick and push-button pins.
// Every channel is an independent debounce_channel; there is no arbitration
// between channels, so simultaneous events are handled in parallel.
// Optional feature: define BUTTON_CONDITIONER_TOGGLE_EN to add the toggle
// output (one bit per channel, flips with each rise pulse).
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int CHANNELS        = 5,
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
`ifdef BUTTON_CONDITIONER_TOGGLE_EN
  output logic [CHANNELS-1:0] toggle,
`endif
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // One conditioner per input pin.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_in[g]),
`ifdef BUTTON_CONDITIONER_TOGGLE_EN
      .toggle (toggle[g]),
`endif
      .level  (level[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with CHANNELS=2, STAGES=2,
// DEBOUNCE_CYCLES=4. A raw change first sampled at edge k shows on the
// outputs after edge k+STAGES+DEBOUNCE_CYCLES = k+6.
module tb_button_conditioner;

  localparam int CH = 2;

  logic          clk;
  logic          reset;
  logic [CH-1:0] raw_in;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
`ifdef BUTTON_CONDITIONER_TOGGLE_EN
  logic [CH-1:0] toggle;
`endif

  int compared;
  int mismatched;

  button_conditioner #(
    .CHANNELS        (2),
    .STAGES          (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_in (raw_in),
`ifdef BUTTON_CONDITIONER_TOGGLE_EN
    .toggle (toggle),
`endif
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    raw_in = 2'b11;
    tick(3);
    compared++;
    if (level !== 2'b00) begin mismatched++; $display("FAIL reset_level: got %b want %b", level, 2'b00); end
    compared++;
    if (rise !== 2'b00) begin mismatched++; $display("FAIL reset_rise: got %b want %b", rise, 2'b00); end
    compared++;
    if (fall !== 2'b00) begin mismatched++; $display("FAIL reset_fall: got %b want %b", fall, 2'b00); end
    reset = 1'b1;
    // First edge after release samples raw (k); outputs move after k+6.
    tick(6);
    compared++;
    if (level !== 2'b00) begin mismatched++; $display("FAIL release_early_level: got %b want %b", level, 2'b00); end
    tick(1);
    compared++;
    if (level !== 2'b11) begin mismatched++; $display("FAIL release_level: got %b want %b", level, 2'b11); end
    compared++;
    if (rise !== 2'b11) begin mismatched++; $display("FAIL release_rise: got %b want %b", rise, 2'b11); end
    tick(1);
    compared++;
    if (rise !== 2'b00) begin mismatched++; $display("FAIL release_rise_end: got %b want %b", rise, 2'b00); end
    raw_in = 2'b00;
    tick(7);
    compared++;
    if (fall !== 2'b11) begin mismatched++; $display("FAIL release_fall: got %b want %b", fall, 2'b11); end
    tick(1);
  endtask

  task automatic test_press_release();
    raw_in = 2'b01;
    tick(6);
    compared++;
    if (level !== 2'b00) begin mismatched++; $display("FAIL press_early_level: got %b want %b", level, 2'b00); end
    tick(1);
    compared++;
    if (level !== 2'b01) begin mismatched++; $display("FAIL press_level: got %b want %b", level, 2'b01); end
    compared++;
    if (rise !== 2'b01) begin mismatched++; $display("FAIL press_rise: got %b want %b", rise, 2'b01); end
    compared++;
    if (fall !== 2'b00) begin mismatched++; $display("FAIL press_fall: got %b want %b", fall, 2'b00); end
    tick(1);
    compared++;
    if (rise !== 2'b00) begin mismatched++; $display("FAIL press_rise_end: got %b want %b", rise, 2'b00); end
    raw_in = 2'b00;
    tick(6);
    compared++;
    if (level !== 2'b01) begin mismatched++; $display("FAIL release_early_level0: got %b want %b", level, 2'b01); end
    tick(1);
    compared++;
    if (level !== 2'b00) begin mismatched++; $display("FAIL release_level0: got %b want %b", level, 2'b00); end
    compared++;
    if (fall !== 2'b01) begin mismatched++; $display("FAIL release_fall0: got %b want %b", fall, 2'b01); end
    compared++;
    if (rise !== 2'b00) begin mismatched++; $display("FAIL release_rise0: got %b want %b", rise, 2'b00); end
    tick(1);
    compared++;
    if (fall !== 2'b00) begin mismatched++; $display("FAIL release_fall0_end: got %b want %b", fall, 2'b00); end
  endtask

  task automatic test_glitch();
    logic seen;
    // Glitch of 3 cycles, then the longest rejectable glitch (4 cycles).
    for (int len = 3; len <= 4; len++) begin
      seen   = 1'b0;
      raw_in = 2'b01;
      tick(len);
      raw_in = 2'b00;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (rise[0] || level[0]) seen = 1'b1;
      end
      compared++;
      if (seen !== 1'b0) begin mismatched++; $display("FAIL glitch_%0d: got activity %b want %b", len, seen, 1'b0); end
    end
    // A clean press afterwards must take the full latency from S_LOW.
    raw_in = 2'b01;
    tick(6);
    compared++;
    if (level !== 2'b00) begin mismatched++; $display("FAIL post_glitch_early: got %b want %b", level, 2'b00); end
    tick(1);
    compared++;
    if (rise !== 2'b01) begin mismatched++; $display("FAIL post_glitch_rise: got %b want %b", rise, 2'b01); end
    raw_in = 2'b00;
    tick(8);
    compared++;
    if (level !== 2'b00) begin mismatched++; $display("FAIL post_glitch_low: got %b want %b", level, 2'b00); end
  endtask

  task automatic test_reset_mid();
    raw_in = 2'b01;
    tick(8);
    compared++;
    if (level !== 2'b01) begin mismatched++; $display("FAIL mid_setup_level: got %b want %b", level, 2'b01); end
    raw_in = 2'b11;
    tick(4);
    // ch1 is now in S_WAIT_HIGH; reset between edges.
    #3;
    reset = 1'b0;
    #1;
    compared++;
    if (level !== 2'b00) begin mismatched++; $display("FAIL mid_async_level: got %b want %b", level, 2'b00); end
    compared++;
    if ((rise | fall) !== 2'b00) begin mismatched++; $display("FAIL mid_async_pulses: got %b want %b", rise | fall, 2'b00); end
    tick(2);
    compared++;
    if (level !== 2'b00) begin mismatched++; $display("FAIL mid_held_level: got %b want %b", level, 2'b00); end
    reset = 1'b1;
    tick(6);
    compared++;
    if (level !== 2'b00) begin mismatched++; $display("FAIL mid_restart_early: got %b want %b", level, 2'b00); end
    tick(1);
    compared++;
    if (rise !== 2'b11) begin mismatched++; $display("FAIL mid_restart_rise: got %b want %b", rise, 2'b11); end
    tick(1);
    compared++;
    if (rise !== 2'b00) begin mismatched++; $display("FAIL mid_restart_rise_end: got %b want %b", rise, 2'b00); end
  endtask

  task automatic test_simultaneous();
    raw_in = 2'b10;
    tick(8);
    compared++;
    if (level !== 2'b10) begin mismatched++; $display("FAIL simul_setup_level: got %b want %b", level, 2'b10); end
    raw_in = 2'b01;
    tick(6);
    compared++;
    if ((rise | fall) !== 2'b00) begin mismatched++; $display("FAIL simul_early_pulses: got %b want %b", rise | fall, 2'b00); end
    tick(1);
    compared++;
    if (rise !== 2'b01) begin mismatched++; $display("FAIL simul_rise: got %b want %b", rise, 2'b01); end
    compared++;
    if (fall !== 2'b10) begin mismatched++; $display("FAIL simul_fall: got %b want %b", fall, 2'b10); end
    compared++;
    if (level !== 2'b01) begin mismatched++; $display("FAIL simul_level: got %b want %b", level, 2'b01); end
    tick(1);
    compared++;
    if ((rise | fall) !== 2'b00) begin mismatched++; $display("FAIL simul_pulses_end: got %b want %b", rise | fall, 2'b00); end
  endtask

`ifdef BUTTON_CONDITIONER_TOGGLE_EN
  task automatic test_toggle();
    logic exp;
    reset  = 1'b0;
    raw_in = 2'b00;
    tick(2);
    compared++;
    if (toggle !== 2'b00) begin mismatched++; $display("FAIL toggle_reset: got %b want %b", toggle, 2'b00); end
    reset = 1'b1;
    exp   = 1'b0;
    for (int p = 0; p < 3; p++) begin
      raw_in = 2'b01;
      tick(6);
      compared++;
      if (toggle !== {1'b0, exp}) begin mismatched++; $display("FAIL toggle_before_%0d: got %b want %b", p, toggle, {1'b0, exp}); end
      tick(1);
      exp = ~exp;
      compared++;
      if (toggle !== {1'b0, exp}) begin mismatched++; $display("FAIL toggle_press_%0d: got %b want %b", p, toggle, {1'b0, exp}); end
      compared++;
      if (rise !== 2'b01) begin mismatched++; $display("FAIL toggle_rise_%0d: got %b want %b", p, rise, 2'b01); end
      raw_in = 2'b00;
      tick(8);
    end
  endtask
`endif

  // Hard bound on run time in case the flow above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    raw_in     = '0;
    test_reset();
    test_press_release();
    test_glitch();
    test_reset_mid();
    test_simultaneous();
`ifdef BUTTON_CONDITIONER_TOGGLE_EN
    test_toggle();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel input conditioner for the joystick and push-button interface.
- Each channel passes an asynchronous raw input through a parametrised-depth synchroniser, then through a debounce state machine.
- Per channel it outputs a clean level, a one-cycle press (rise) pulse and a one-cycle release (fall) pulse.
- Sits between the board pins and the sprite-movement control logic; replaces separate per-button synchroniser and debouncer instances.

Parameters:
- CHANNELS, 5, number of independent input channels (≥1).
- STAGES, 2, synchroniser flip-flop depth per channel (≥2).
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must stay stable before the level changes (≥1); 20 ms at 50 MHz.
- CNT_W, derived localparam $clog2(DEBOUNCE_CYCLES+1), counter width; not overridable.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset: reset=0 clears all state immediately.
- raw_in  input  CHANNELS  asynchronous raw inputs, bit i = channel i.
- level  output  CHANNELS  debounced level per channel.
- rise  output  CHANNELS  one-cycle pulse on a debounced 0→1 change.
- fall  output  CHANNELS  one-cycle pulse on a debounced 1→0 change.

Behaviour:
- Reset values:
  - All synchroniser flops 0.
  - All FSMs in S_LOW, all counters 0.
  - level, rise and fall all 0.
- Synchroniser:
  - Per channel, a STAGES-deep shift register with raw_in entering the first stage.
  - sync_i is the last stage.
  - A raw change sampled at edge k is visible on sync_i after edge k+STAGES-1.
- FSM per channel, states S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW:
  - S_LOW: sync=1 → S_WAIT_HIGH, count←0; else stay.
  - S_WAIT_HIGH, sync=0 → S_LOW, count←0; glitch rejected, no pulse.
  - S_WAIT_HIGH, sync=1, count==DEBOUNCE_CYCLES-1 → S_HIGH, rise pulse.
  - S_WAIT_HIGH, sync=1, otherwise → count←count+1.
  - S_HIGH and S_WAIT_LOW mirror the two rows above with polarity inverted; the S_WAIT_LOW→S_LOW transition asserts fall.
- level = 1 in S_HIGH and S_WAIT_LOW.
  - level is registered and changes on the same edge as the state change into S_HIGH or S_LOW.
- rise and fall are registered.
  - Each is high for exactly the one cycle after the transition edge.
  - rise and fall of the same channel are never high together.
- Latency: raw input changes before edge k and is then held → level changes and the pulse asserts after edge k+STAGES+DEBOUNCE_CYCLES.
- Counter:
  - Saturates by construction: it never exceeds DEBOUNCE_CYCLES-1.
  - No wrap-around.
  - Cleared on every entry into a WAIT state.
- Channels are fully independent. Simultaneous events on any number of channels are handled in parallel, with no arbitration.
- Raw input high at reset release: the channel starts in S_LOW and produces a normal rise pulse after the full latency.
- Reset asserted mid-debounce: the count is lost, and the channel restarts from S_LOW on release.
- A bounce shorter than DEBOUNCE_CYCLES cycles (after synchronisation) produces no output change.

Optional Feature:
- Macro: BUTTON_CONDITIONER_TOGGLE_EN.
- When defined:
  - Adds output toggle [CHANNELS-1:0], reset 0.
  - Bit i inverts on the edge after which rise[i] is high, so it changes together with rise and is registered.
  - Used for on/off sprite modes.
- When undefined: the port and its flops are absent; all other behaviour is identical.

Decomposition:
- Package button_conditioner_pkg holds:
  - the state typedef enum logic [1:0] {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW};
  - a function computing CNT_W.
- One sub-module, debounce_channel, contains:
  - the synchroniser;
  - the FSM;
  - the counter;
  - the optional toggle bit.
- The top level instantiates it CHANNELS times with a generate loop.

Test Plan (CHANNELS=2, STAGES=2, DEBOUNCE_CYCLES=4):
1. Reset: hold reset=0 with raw_in=2'b11 → level, rise and fall are 0; release → ch0 and ch1 level=1 and rise=1 after edge 6 post-release, rise low one cycle later.
2. Clean press and release on ch0: raw_in[0] 0→1 before edge k → level[0]=1 and rise[0]=1 after edge k+6; then 1→0 before edge m → level[0]=0 and fall[0]=1 after edge m+6.
3. Glitch: raw_in[0] high for 3 cycles then low → level[0] stays 0, no rise pulse, FSM returns to S_LOW.
4. Reset mid-debounce: assert reset=0 asynchronously between edges while ch1 is in S_WAIT_HIGH → all outputs 0 at once; after release, with raw held high, rise[1] appears 6 edges later.
5. Simultaneous activity: ch0 press and ch1 release on the same edge → rise[0] and fall[1] high in the same cycle; no cross-channel effect.
6. BUTTON_CONDITIONER_TOGGLE_EN defined: three clean presses on ch0 → toggle[0] sequence 1,0,1, each change aligned with rise[0]; toggle[1] stays 0.
